// File: rtl/mem_stage_data_memory_pkg.sv
// rtl/mem_stage_data_memory_pkg.sv - shared widths, BHW size codes and access helpers for the MEM-stage data memory
package mem_stage_data_memory_pkg;

    localparam int NB_WIDTH_DEF = 32;
    localparam int NB_ADDR_DEF  = 9;
    localparam int NB_DATA_DEF  = 8;
    localparam int NB_LANES     = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int BHW_UNSIGNED_BIT = 2;

    typedef struct packed {
        logic       is_unsigned;
        logic [1:0] size;
    } bhw_t;

    // Unused code 2'b10 falls through to a full-word access.
    function automatic logic [NB_LANES-1:0] lane_mask(input logic [1:0] size);
        logic [NB_LANES-1:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsb);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lsb[0];
            default: mis = |addr_lsb;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_data_memory_byte_ram.sv
// rtl/mem_stage_data_memory_byte_ram.sv - byte-cell RAM with async clear and four independent byte-lane ports
module mem_byte_ram
    import mem_stage_data_memory_pkg::*;
#(
    parameter int NB_ADDR = NB_ADDR_DEF,
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [NB_LANES-1:0]                 i_lane_we,
    input  logic [NB_LANES-1:0][NB_ADDR-1:0]    i_lane_addr,
    input  logic [NB_LANES-1:0][NB_DATA-1:0]    i_lane_wdata,
    output logic [NB_LANES-1:0][NB_DATA-1:0]    o_lane_rdata
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] r_mem [DEPTH];

    // Lane addresses are consecutive modulo DEPTH, so lanes never collide on one cell.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int l = 0; l < NB_LANES; l++) begin
                if (i_lane_we[l]) begin
                    r_mem[i_lane_addr[l]] <= i_lane_wdata[l];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NB_LANES; l++) begin
            o_lane_rdata[l] = r_mem[i_lane_addr[l]];
        end
    end

endmodule

// File: rtl/mem_stage_data_memory.sv
// rtl/mem_stage_data_memory.sv - MIPS MEM-stage byte-addressable data memory with sized, sign/zero-extended loads
// Optional MEM_ALIGN_CHECK_EN adds o_misaligned and suppresses misaligned CU stores.
module mem_stage_data_memory
    import mem_stage_data_memory_pkg::*;
#(
    parameter int NB_WIDTH = NB_WIDTH_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int NB_DATA  = NB_DATA_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_WIDTH-1:0] i_mem_addr,
    input  logic [NB_WIDTH-1:0] i_mem_data,
    input  logic                i_mem_read_CU,
    input  logic                i_mem_write_CU,
    input  logic                i_dunit_r_data,
    input  logic [2:0]          i_BHW_CU,
    output logic [NB_WIDTH-1:0] o_read_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                o_misaligned
`endif
);

    logic [NB_ADDR-1:0]                 w_base;
    logic [NB_LANES-1:0][NB_ADDR-1:0]   w_lane_addr;
    logic [NB_LANES-1:0][NB_DATA-1:0]   w_lane_wdata;
    logic [NB_LANES-1:0][NB_DATA-1:0]   w_lane_rdata;
    logic [NB_LANES-1:0]                w_lane_we;
    logic [NB_WIDTH-1:0]                w_rd_word;
    logic [NB_WIDTH-1:0]                w_load;
    logic                               w_read_en;
    logic                               w_write_ok;
    logic                               w_ext_byte;
    logic                               w_ext_half;
    bhw_t                               w_bhw_cu;
    bhw_t                               w_bhw_rd;
    logic [NB_WIDTH-1:0]                r_read_data;
    logic [NB_WIDTH-NB_ADDR-1:0]        w_unused_addr;

    assign w_unused_addr = i_mem_addr[NB_WIDTH-1:NB_ADDR];
    assign w_base        = i_mem_addr[NB_ADDR-1:0];
    assign w_bhw_cu      = bhw_t'(i_BHW_CU);
    assign w_read_en     = i_mem_read_CU | i_dunit_r_data;

    // Debug-unit reads always fetch a whole word regardless of the CU size code.
    always_comb begin
        w_bhw_rd = w_bhw_cu;
        if (i_dunit_r_data) begin
            w_bhw_rd.size        = SZ_WORD;
            w_bhw_rd.is_unsigned = 1'b1;
        end
    end

    always_comb begin
        for (int l = 0; l < NB_LANES; l++) begin
            w_lane_addr[l]  = w_base + NB_ADDR'(l);
            w_lane_wdata[l] = i_mem_data[l*NB_DATA +: NB_DATA];
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic w_misaligned;
    logic w_cu_access;
    logic r_misaligned;

    assign w_misaligned = is_misaligned(w_bhw_cu.size, w_base[1:0]);
    assign w_cu_access  = i_mem_read_CU | i_mem_write_CU;
    assign w_write_ok   = i_mem_write_CU & ~w_misaligned;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_misaligned <= 1'b0;
        end else if (w_cu_access) begin
            r_misaligned <= w_misaligned;
        end
    end

    assign o_misaligned = r_misaligned;
`else
    assign w_write_ok = i_mem_write_CU;
`endif

    assign w_lane_we = w_write_ok ? lane_mask(w_bhw_cu.size) : '0;

    mem_byte_ram #(
        .NB_ADDR (NB_ADDR),
        .NB_DATA (NB_DATA)
    ) u_ram (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_lane_we    (w_lane_we),
        .i_lane_addr  (w_lane_addr),
        .i_lane_wdata (w_lane_wdata),
        .o_lane_rdata (w_lane_rdata)
    );

    assign w_rd_word  = NB_WIDTH'(w_lane_rdata);
    assign w_ext_byte = ~w_bhw_rd.is_unsigned & w_rd_word[NB_DATA-1];
    assign w_ext_half = ~w_bhw_rd.is_unsigned & w_rd_word[2*NB_DATA-1];

    always_comb begin
        w_load = w_rd_word;
        case (w_bhw_rd.size)
            SZ_BYTE: w_load = {{(NB_WIDTH-NB_DATA){w_ext_byte}}, w_rd_word[NB_DATA-1:0]};
            SZ_HALF: w_load = {{(NB_WIDTH-2*NB_DATA){w_ext_half}}, w_rd_word[2*NB_DATA-1:0]};
            default: w_load = w_rd_word;
        endcase
    end

    // The RAM array updates on the same edge, so sampling here gives read-before-write.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_read_data <= '0;
        end else if (w_read_en) begin
            r_read_data <= w_load;
        end
    end

    assign o_read_data = r_read_data;

endmodule

// File: tb/tb_mem_stage_data_memory.sv
// tb/tb_mem_stage_data_memory.sv - directed self-checking bench for mem_stage_data_memory
module tb_mem_stage_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rd;
    logic        wr;
    logic        dunit;
    logic [2:0]  bhw;
    logic [31:0] rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    int total;
    int bad;

    mem_stage_data_memory dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_mem_addr     (addr),
        .i_mem_data     (data),
        .i_mem_read_CU  (rd),
        .i_mem_write_CU (wr),
        .i_dunit_r_data (dunit),
        .i_BHW_CU       (bhw),
        .o_read_data    (rdata)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .o_misaligned   (misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] b);
        addr = a; data = d; bhw = b; wr = 1'b1; rd = 1'b0; dunit = 1'b0;
        step();
        wr = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] b);
        addr = a; bhw = b; rd = 1'b1; wr = 1'b0; dunit = 1'b0;
        step();
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = '0; data = '0; rd = 1'b0; wr = 1'b0; dunit = 1'b0; bhw = 3'b011;
        step(); step();
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=%h", rdata, 32'h0); end
        rst = 1'b0;
        step();
        load(32'd0, 3'b011);
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL reset_lw0 got=%h exp=%h", rdata, 32'h0); end
    endtask

    task automatic test_byte();
        store(32'd4, 32'h000000FF, 3'b000);
        load(32'd4, 3'b000);
        total++;
        if (rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL lb_4 got=%h exp=%h", rdata, 32'hFFFFFFFF); end
        load(32'd4, 3'b100);
        total++;
        if (rdata !== 32'h000000FF) begin bad++; $display("FAIL lbu_4 got=%h exp=%h", rdata, 32'h000000FF); end
    endtask

    task automatic test_half();
        store(32'd8, 32'h0000A5A5, 3'b001);
        load(32'd8, 3'b001);
        total++;
        if (rdata !== 32'hFFFFA5A5) begin bad++; $display("FAIL lh_8 got=%h exp=%h", rdata, 32'hFFFFA5A5); end
        store(32'd20, 32'h0000FF00, 3'b101);
        load(32'd20, 3'b101);
        total++;
        if (rdata !== 32'h0000FF00) begin bad++; $display("FAIL lhu_20 got=%h exp=%h", rdata, 32'h0000FF00); end
    endtask

    task automatic test_word();
        store(32'd12, 32'hDEADBEEF, 3'b011);
        load(32'd12, 3'b011);
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_12 got=%h exp=%h", rdata, 32'hDEADBEEF); end
        load(32'd13, 3'b000);
        total++;
        if (rdata !== 32'hFFFFFFBE) begin bad++; $display("FAIL lb_13 got=%h exp=%h", rdata, 32'hFFFFFFBE); end
        load(32'd15, 3'b100);
        total++;
        if (rdata !== 32'h000000DE) begin bad++; $display("FAIL lbu_15 got=%h exp=%h", rdata, 32'h000000DE); end
        load(32'd14, 3'b001);
        total++;
        if (rdata !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh_14 got=%h exp=%h", rdata, 32'hFFFFDEAD); end
    endtask

    task automatic test_byte_preserve();
        store(32'd16, 32'h0F0000FF, 3'b100);
        load(32'd16, 3'b011);
        total++;
        if (rdata !== 32'h000000FF) begin bad++; $display("FAIL sb_upper_16 got=%h exp=%h", rdata, 32'h000000FF); end
    endtask

    task automatic test_size_code_10();
        store(32'd24, 32'h12345678, 3'b010);
        load(32'd24, 3'b110);
        total++;
        if (rdata !== 32'h12345678) begin bad++; $display("FAIL code10_24 got=%h exp=%h", rdata, 32'h12345678); end
    endtask

    task automatic test_dunit();
        addr = 32'd12; bhw = 3'b000; dunit = 1'b1; rd = 1'b0; wr = 1'b0;
        step();
        dunit = 1'b0;
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL dunit_12 got=%h exp=%h", rdata, 32'hDEADBEEF); end
    endtask

    task automatic test_hold();
        rd = 1'b0; wr = 1'b0; dunit = 1'b0; addr = 32'd4; bhw = 3'b000;
        step(); step();
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hold got=%h exp=%h", rdata, 32'hDEADBEEF); end
    endtask

    task automatic test_read_before_write();
        addr = 32'd12; data = 32'h11111111; bhw = 3'b011; rd = 1'b1; wr = 1'b1; dunit = 1'b0;
        step();
        wr = 1'b0;
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rbw_old got=%h exp=%h", rdata, 32'hDEADBEEF); end
        step();
        rd = 1'b0;
        total++;
        if (rdata !== 32'h11111111) begin bad++; $display("FAIL rbw_new got=%h exp=%h", rdata, 32'h11111111); end
    endtask

`ifndef MEM_ALIGN_CHECK_EN
    task automatic test_wrap_alias();
        store(32'd510, 32'hAABBCCDD, 3'b011);
        load(32'd0, 3'b011);
        total++;
        if (rdata !== 32'h0000AABB) begin bad++; $display("FAIL wrap_lw0 got=%h exp=%h", rdata, 32'h0000AABB); end
        load(32'd510, 3'b001);
        total++;
        if (rdata !== 32'hFFFFCCDD) begin bad++; $display("FAIL wrap_lh510 got=%h exp=%h", rdata, 32'hFFFFCCDD); end
        load(32'h000003FE, 3'b011);
        total++;
        if (rdata !== 32'hAABBCCDD) begin bad++; $display("FAIL alias_lw got=%h exp=%h", rdata, 32'hAABBCCDD); end
    endtask
`else
    task automatic test_misaligned();
        store(32'd50, 32'hCAFECAFE, 3'b011);
        total++;
        if (misaligned !== 1'b1) begin bad++; $display("FAIL mis_flag got=%b exp=1", misaligned); end
        load(32'd48, 3'b011);
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL mis_suppress got=%h exp=%h", rdata, 32'h0); end
        total++;
        if (misaligned !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misaligned); end
    endtask
`endif

    task automatic test_reset_midop();
        store(32'd40, 32'hCAFEF00D, 3'b011);
        load(32'd40, 3'b011);
        total++;
        if (rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL pre_rst_40 got=%h exp=%h", rdata, 32'hCAFEF00D); end
        addr = 32'd44; data = 32'h55AA55AA; bhw = 3'b011; wr = 1'b1; rd = 1'b1;
        rst = 1'b1;
        #1;
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL async_rst got=%h exp=%h", rdata, 32'h0); end
        step();
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
        step();
        load(32'd40, 3'b011);
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL rst_clear_40 got=%h exp=%h", rdata, 32'h0); end
        load(32'd44, 3'b011);
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL rst_nowrite_44 got=%h exp=%h", rdata, 32'h0); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_byte();
        test_half();
        test_word();
        test_byte_preserve();
        test_size_code_10();
        test_dunit();
        test_hold();
        test_read_before_write();
`ifndef MEM_ALIGN_CHECK_EN
        test_wrap_alias();
`else
        test_misaligned();
`endif
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_data_memory.md
Name: mem_stage_data_memory

Overview:
MIPS pipeline MEM-stage data memory: a byte-addressable RAM serving loads and stores from the control unit (SB/SH/SW, LB/LH/LW, LBU/LHU). It also serves word reads from the debug unit. It sits between EX/MEM and MEM/WB; o_read_data feeds write-back.

Parameters:
NB_WIDTH, 32, data/address bus width.
NB_ADDR, 9, byte-address bits used (2^9 = 512 bytes).
NB_DATA, 8, bits per memory cell (one byte).

Ports:
i_clk  in  1  system clock, rising-edge active.
i_reset  in  1  asynchronous, active-high reset.
i_mem_addr  in  NB_WIDTH  byte address; only bits [NB_ADDR-1:0] used.
i_mem_data  in  NB_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
i_mem_read_CU  in  1  load enable from control unit.
i_mem_write_CU  in  1  store enable from control unit.
i_dunit_r_data  in  1  debug-unit read request: full word, no extension.
i_BHW_CU  in  3  access size/sign: [1:0] 00 byte, 01 half, 11 word; [2] 1 = unsigned (zero-extend).
o_read_data  out  NB_WIDTH  registered load result.

Behaviour:
- Reset (async, high): o_read_data = 0; all 512 bytes cleared to 0.
- Storage: 2^NB_ADDR bytes, little-endian. Byte at A is [7:0]; A+1 is [15:8], and so on.
- Write on rising edge when i_mem_write_CU=1:
  - byte size: mem[A] <= data[7:0].
  - half size: mem[A..A+1] <= data[15:0].
  - word or any other size code: mem[A..A+3] <= data.
  - i_BHW_CU[2] ignored on writes.
- Read on rising edge when i_mem_read_CU=1 or i_dunit_r_data=1. o_read_data is loaded with:
  - byte: mem[A], sign-extended from bit 7 (or zero-extended if [2]=1).
  - half: {mem[A+1], mem[A]}, sign-extended from bit 15 (or zero-extended if [2]=1).
  - word (11 or unused codes 10): {mem[A+3]..mem[A]}, no extension.
- i_dunit_r_data=1 overrides i_BHW_CU and forces a word read.
- Latency: result visible after the rising edge at which the read is sampled (1 cycle).
- o_read_data holds its value while no read is enabled.
- Simultaneous read and write to overlapping bytes: read returns pre-write contents (read-before-write).
- Alignment is not enforced. Multi-byte accesses use consecutive byte addresses modulo 2^NB_ADDR (wrap from 511 to 0).
- Address bits above NB_ADDR-1 are ignored (aliasing).
- Reset asserted mid-operation wins over any same-edge read or write.

Optional Feature:
MEM_ALIGN_CHECK_EN:
- Defined: adds output o_misaligned (1 bit, registered, reset 0). It is set on the edge of any CU read or write where a half access has A[0]≠0 or a word access has A[1:0]≠0. Misaligned writes are suppressed (memory unchanged). Misaligned reads still update o_read_data.
- Undefined: no extra port; all accesses proceed as above.

Decomposition:
- Shared package: NB_* defaults, and BHW size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b11, plus the unsigned-bit index 2.
- One sub-module, mem_byte_ram: byte array with async clear and 4 byte-lane write enables.
- The top holds lane generation and load extension.

Test Plan:
- Pulse reset; read word at 0 -> o_read_data=00000000.
- Store byte 0x000000FF at addr 4 (BHW 000); LB at 4 -> FFFFFFFF. LBU (100) at 4 -> 000000FF.
- Store half 0x0000A5A5 at addr 8 (001); LH -> FFFFA5A5. Store half 0x0000FF00 at addr 20 (101); LHU -> 0000FF00.
- Store word DEADBEEF at addr 12 (011); LW -> DEADBEEF. LB at 13 -> FFFFFFBE. LBU at 15 -> 000000DE.
- Store byte 0x0F0000FF at addr 16 (100); LW at 16 -> 000000FF, confirming the upper bytes are untouched.
- i_dunit_r_data=1 with BHW 000 at addr 12 -> DEADBEEF. Simultaneous write 11111111 and read at 12 -> read returns DEADBEEF, then the next read returns 11111111.
